// File: rtl/pin_route_sequencer.sv
// Sequences pin-route mux changes: gate affected drivers and freeze inputs, drain,
// switch the select, settle, then release. Prop Plug wins pmodD over the alternate PS/2 route.
module pin_route_sequencer #(
  parameter int unsigned DRAIN_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic       clk_cog,
  input  logic       nres,
  input  logic [3:0] req_sel,
  input  logic       hold,
  output logic [3:0] route_sel,
  output logic [3:0] oe_gate,
  output logic [3:0] in_freeze,
  output logic       busy,
  output logic       conflict,
  output logic       change_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] DRAIN_LOAD  = 16'(DRAIN_CYCLES - 32'd1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 32'd1);

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  pend_r, pend_s;
  logic [3:0]  target_r, target_s;
  logic [3:0]  route_r, route_s;
  logic [3:0]  oe_r, oe_s;
  logic [3:0]  freeze_r, freeze_s;
  logic        busy_r, busy_s;
  logic        conflict_r;
  logic        pulse_r, pulse_s;
  logic [3:0]  eff_s;
  logic [3:0]  diff_s;

  // Prop Plug on pmodD masks the alternate PS/2 request.
  assign eff_s  = {req_sel[3:1], req_sel[0] & ~req_sel[3]};
  assign diff_s = eff_s ^ route_r;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pend_s   = pend_r;
    target_s = target_r;
    route_s  = route_r;
    oe_s     = oe_r;
    freeze_s = freeze_r;
    busy_s   = busy_r;
    pulse_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if ((diff_s != 4'b0000) && !hold) begin
          pend_s   = diff_s;
          target_s = eff_s;
          oe_s     = ~diff_s;
          freeze_s = diff_s;
          busy_s   = 1'b1;
          cnt_s    = DRAIN_LOAD;
          state_s  = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (cnt_r == 16'd0) begin
          state_s = SWITCH;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      SWITCH: begin
        route_s = (route_r & ~pend_r) | (target_r & pend_r);
        pulse_s = 1'b1;
        cnt_s   = SETTLE_LOAD;
        state_s = SETTLE;
      end
      SETTLE: begin
        if (cnt_r == 16'd0) begin
          oe_s     = 4'b1111;
          freeze_s = 4'b0000;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r - 16'd1;
        end
      end
      default: begin
        oe_s     = 4'b1111;
        freeze_s = 4'b0000;
        busy_s   = 1'b0;
        cnt_s    = 16'd0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      pend_r     <= 4'b0000;
      target_r   <= 4'b0000;
      route_r    <= 4'b0000;
      oe_r       <= 4'b1111;
      freeze_r   <= 4'b0000;
      busy_r     <= 1'b0;
      conflict_r <= 1'b0;
      pulse_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pend_r     <= pend_s;
      target_r   <= target_s;
      route_r    <= route_s;
      oe_r       <= oe_s;
      freeze_r   <= freeze_s;
      busy_r     <= busy_s;
      conflict_r <= req_sel[3] & req_sel[0];
      pulse_r    <= pulse_s;
    end
  end

  assign route_sel    = route_r;
  assign oe_gate      = oe_r;
  assign in_freeze    = freeze_r;
  assign busy         = busy_r;
  assign conflict     = conflict_r;
  assign change_pulse = pulse_r;

endmodule

// File: tb/tb_pin_route_sequencer.sv
// Directed bench for pin_route_sequencer: default timing instance plus a 1/1 short-timing instance.
module tb_pin_route_sequencer;

  logic       clk;
  logic       nres;
  logic [3:0] req_sel;
  logic       hold;
  logic [3:0] route_sel, oe_gate, in_freeze;
  logic       busy, conflict, change_pulse;

  logic [3:0] s_req;
  logic       s_hold;
  logic [3:0] s_route, s_oe, s_freeze;
  logic       s_busy, s_conflict, s_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int p0;

  pin_route_sequencer dut (
    .clk_cog(clk), .nres(nres), .req_sel(req_sel), .hold(hold),
    .route_sel(route_sel), .oe_gate(oe_gate), .in_freeze(in_freeze),
    .busy(busy), .conflict(conflict), .change_pulse(change_pulse)
  );

  pin_route_sequencer #(.DRAIN_CYCLES(1), .SETTLE_CYCLES(1)) dut_short (
    .clk_cog(clk), .nres(nres), .req_sel(s_req), .hold(s_hold),
    .route_sel(s_route), .oe_gate(s_oe), .in_freeze(s_freeze),
    .busy(s_busy), .conflict(s_conflict), .change_pulse(s_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (change_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nres = 1'b1; req_sel = 4'b0000; hold = 1'b0; s_req = 4'b0000; s_hold = 1'b0;
    #1 nres = 1'b0;
    #2;
    checks++; if (route_sel !== 4'b0000) begin errors++; $display("FAIL rst_route got %b exp 0000", route_sel); end
    checks++; if (oe_gate !== 4'b1111) begin errors++; $display("FAIL rst_oe got %b exp 1111", oe_gate); end
    checks++; if (in_freeze !== 4'b0000 || busy !== 1'b0 || conflict !== 1'b0 || change_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_misc got fr=%b busy=%b conf=%b pulse=%b exp 0000/0/0/0", in_freeze, busy, conflict, change_pulse); end
    tick(2);
    nres = 1'b1;
    tick(20);
    checks++; if (route_sel !== 4'b0000 || oe_gate !== 4'b1111 || busy !== 1'b0 || in_freeze !== 4'b0000) begin
      errors++; $display("FAIL idle_stable got route=%b oe=%b busy=%b fr=%b exp 0000/1111/0/0000", route_sel, oe_gate, busy, in_freeze); end
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL idle_no_pulse got %0d exp 0", pulse_cnt); end
    checks++; if (s_busy !== 1'b0 || s_route !== 4'b0000) begin errors++; $display("FAIL short_idle got busy=%b route=%b exp 0/0000", s_busy, s_route); end
  endtask

  task automatic test_single;
    p0 = pulse_cnt;
    req_sel = 4'b0010;
    tick(1); // E0
    checks++; if (oe_gate !== 4'b1101 || in_freeze !== 4'b0010 || busy !== 1'b1) begin
      errors++; $display("FAIL single_e0 got oe=%b fr=%b busy=%b exp 1101/0010/1", oe_gate, in_freeze, busy); end
    tick(16); // E0+16
    checks++; if (route_sel !== 4'b0000 || change_pulse !== 1'b0) begin
      errors++; $display("FAIL single_e16 got route=%b pulse=%b exp 0000/0", route_sel, change_pulse); end
    tick(1); // E0+17
    checks++; if (route_sel !== 4'b0010 || change_pulse !== 1'b1) begin
      errors++; $display("FAIL single_e17 got route=%b pulse=%b exp 0010/1", route_sel, change_pulse); end
    tick(1);
    checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_clear got %b exp 0", change_pulse); end
    tick(62); // E0+80
    checks++; if (busy !== 1'b1 || oe_gate !== 4'b1101 || in_freeze !== 4'b0010) begin
      errors++; $display("FAIL single_e80 got busy=%b oe=%b fr=%b exp 1/1101/0010", busy, oe_gate, in_freeze); end
    tick(1); // E0+81
    checks++; if (busy !== 1'b0 || oe_gate !== 4'b1111 || in_freeze !== 4'b0000 || route_sel !== 4'b0010) begin
      errors++; $display("FAIL single_e81 got busy=%b oe=%b fr=%b route=%b exp 0/1111/0000/0010", busy, oe_gate, in_freeze, route_sel); end
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL single_pulse_count got %0d exp 1", pulse_cnt - p0); end
  endtask

  task automatic test_conflict;
    req_sel = 4'b1001;
    tick(1); // E0, pend 1010
    checks++; if (conflict !== 1'b1 || oe_gate !== 4'b0101 || in_freeze !== 4'b1010) begin
      errors++; $display("FAIL conf_e0 got conf=%b oe=%b fr=%b exp 1/0101/1010", conflict, oe_gate, in_freeze); end
    tick(17);
    checks++; if (route_sel !== 4'b1000) begin errors++; $display("FAIL conf_route got %b exp 1000", route_sel); end
    tick(64);
    checks++; if (busy !== 1'b0 || conflict !== 1'b1) begin errors++; $display("FAIL conf_end got busy=%b conf=%b exp 0/1", busy, conflict); end
    req_sel = 4'b0001;
    tick(1); // pend 1001
    checks++; if (conflict !== 1'b0 || oe_gate !== 4'b0110 || in_freeze !== 4'b1001) begin
      errors++; $display("FAIL conf2_e0 got conf=%b oe=%b fr=%b exp 0/0110/1001", conflict, oe_gate, in_freeze); end
    tick(17);
    checks++; if (route_sel !== 4'b0001) begin errors++; $display("FAIL conf2_route got %b exp 0001", route_sel); end
    tick(64);
    checks++; if (busy !== 1'b0 || oe_gate !== 4'b1111) begin errors++; $display("FAIL conf2_end got busy=%b oe=%b exp 0/1111", busy, oe_gate); end
  endtask

  task automatic test_hold_and_chain;
    hold = 1'b1; req_sel = 4'b0100;
    tick(5);
    checks++; if (busy !== 1'b0 || oe_gate !== 4'b1111 || route_sel !== 4'b0001) begin
      errors++; $display("FAIL hold_idle got busy=%b oe=%b route=%b exp 0/1111/0001", busy, oe_gate, route_sel); end
    hold = 1'b0;
    tick(1); // E0, pend 0101
    checks++; if (busy !== 1'b1 || oe_gate !== 4'b1010 || in_freeze !== 4'b0101) begin
      errors++; $display("FAIL hold_drop got busy=%b oe=%b fr=%b exp 1/1010/0101", busy, oe_gate, in_freeze); end
    tick(5);
    req_sel = 4'b0110;
    tick(12); // E0+17
    checks++; if (route_sel !== 4'b0100) begin errors++; $display("FAIL chain_first_route got %b exp 0100", route_sel); end
    tick(64); // E0+81
    checks++; if (busy !== 1'b0 || oe_gate !== 4'b1111) begin errors++; $display("FAIL chain_first_end got busy=%b oe=%b exp 0/1111", busy, oe_gate); end
    tick(1); // E1
    checks++; if (busy !== 1'b1 || oe_gate !== 4'b1101 || in_freeze !== 4'b0010) begin
      errors++; $display("FAIL chain_second_start got busy=%b oe=%b fr=%b exp 1/1101/0010", busy, oe_gate, in_freeze); end
    tick(17);
    checks++; if (route_sel !== 4'b0110) begin errors++; $display("FAIL chain_second_route got %b exp 0110", route_sel); end
    tick(64);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chain_second_end got busy=%b exp 0", busy); end
  endtask

  task automatic test_short_timing;
    s_req = 4'b0100;
    tick(1); // E0
    checks++; if (s_busy !== 1'b1 || s_oe !== 4'b1011 || s_route !== 4'b0000) begin
      errors++; $display("FAIL short_e0 got busy=%b oe=%b route=%b exp 1/1011/0000", s_busy, s_oe, s_route); end
    tick(1);
    checks++; if (s_busy !== 1'b1 || s_route !== 4'b0000) begin errors++; $display("FAIL short_e1 got busy=%b route=%b exp 1/0000", s_busy, s_route); end
    tick(1);
    checks++; if (s_busy !== 1'b1 || s_route !== 4'b0100 || s_pulse !== 1'b1) begin
      errors++; $display("FAIL short_e2 got busy=%b route=%b pulse=%b exp 1/0100/1", s_busy, s_route, s_pulse); end
    tick(1);
    checks++; if (s_busy !== 1'b0 || s_oe !== 4'b1111 || s_freeze !== 4'b0000 || s_pulse !== 1'b0) begin
      errors++; $display("FAIL short_e3 got busy=%b oe=%b fr=%b pulse=%b exp 0/1111/0000/0", s_busy, s_oe, s_freeze, s_pulse); end
    s_req = 4'b0000;
    tick(4);
  endtask

  task automatic test_reset_mid;
    req_sel = 4'b0100; // from 0110, pend 0010
    tick(1);
    checks++; if (busy !== 1'b1 || oe_gate !== 4'b1101) begin errors++; $display("FAIL mid_start got busy=%b oe=%b exp 1/1101", busy, oe_gate); end
    tick(27); // inside SETTLE
    checks++; if (route_sel !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL mid_settle got route=%b busy=%b exp 0100/1", route_sel, busy); end
    #2 nres = 1'b0;
    #1;
    checks++; if (route_sel !== 4'b0000 || oe_gate !== 4'b1111 || in_freeze !== 4'b0000 || busy !== 1'b0 || change_pulse !== 1'b0 || conflict !== 1'b0) begin
      errors++; $display("FAIL mid_async_rst got route=%b oe=%b fr=%b busy=%b pulse=%b conf=%b exp 0000/1111/0000/0/0/0",
                         route_sel, oe_gate, in_freeze, busy, change_pulse, conflict); end
    nres = 1'b1;
    tick(1); // first edge after release
    checks++; if (busy !== 1'b1 || oe_gate !== 4'b1011 || in_freeze !== 4'b0100) begin
      errors++; $display("FAIL mid_reseq got busy=%b oe=%b fr=%b exp 1/1011/0100", busy, oe_gate, in_freeze); end
    tick(17);
    checks++; if (route_sel !== 4'b0100) begin errors++; $display("FAIL mid_reseq_route got %b exp 0100", route_sel); end
    tick(64);
    checks++; if (busy !== 1'b0 || oe_gate !== 4'b1111) begin errors++; $display("FAIL mid_reseq_end got busy=%b oe=%b exp 0/1111", busy, oe_gate); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_conflict;
    test_hold_and_chain;
    test_short_timing;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
